seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised multiplexed 7-segment driver. Shows one DATA_W-bit value on N_DIGITS time-scanned digits.
//  Supports hex or decimal mode, leading-zero blanking, 16-step brightness PWM and overflow indication.
//  Replaces the fixed-width per-display mux logic. One instance drives one display bank on the board top level.
// PARAMETERS
//  DATA_W          8       width of binary input value
//  N_DIGITS        4       digits scanned; digit 0 = least significant
//  SCAN_DIV        1600    clocks per digit slot; must be a multiple of 16, >=16
//  ANODE_ACT_LOW   1       1: anode active level is 0
//  SEG_ACT_LOW     1       1: segment-on level is 0
// PORTS
//  clk       in   1          system clock
//  reset     in   1          synchronous, active-high
//  data      in   DATA_W     binary value to display
//  load      in   1          1-cycle strobe: capture data/mode
//  mode      in   1          0 = hex, 1 = decimal
//  blank_lz  in   1          1 = blank leading zeros (live, not captured)
//  bright    in   4          duty: anode on for bright+1 of 16 phases (live)
//  busy      out  1          conversion in progress; load ignored
//  ovf       out  1          value does not fit N_DIGITS in the captured mode
//  anode     out  N_DIGITS   one-hot digit enable (polarity per ANODE_ACT_LOW)
//  seg       out  7          {g,f,e,d,c,b,a} (polarity per SEG_ACT_LOW)
// BEHAVIOUR
//  Reset: prescaler, phase, digit index, display regs, busy and ovf cleared to 0.
//   anode all inactive, seg all off while reset is high. The first post-reset digit shows '0'.
//  Load: sampled only when load=1 and busy=0; a load while busy is dropped, with no queueing.
//   Hex: nibbles are written to the display reg on the next cycle. busy stays 0.
//   Decimal: seg7_bin2bcd runs one shift per clock. busy=1 starting the cycle after load, for exactly DATA_W cycles.
//    The display reg and ovf update atomically in the cycle busy falls.
//  The display keeps showing the old value until the update. There is no partial or intermediate digit.
//  Scan: prescaler counts 0..SCAN_DIV/16-1. On wrap, phase (0..15) increments.
//   On phase wrap 15->0, the digit index advances mod N_DIGITS: wrap N_DIGITS-1 -> 0.
//  PWM: anode[idx] is active iff phase <= bright. bright=15 gives full on; bright=0 gives 1/16. Other anodes are inactive.
//  anode/seg are registered: 1-cycle latency from index/phase change. Both are driven from the same flop stage, so there is no ghosting.
//  Glyphs: 0-9 and A,b,C,d,E,F use the standard patterns. SEG_DASH = segment g only. SEG_OFF = none.
//  Blanking: if blank_lz=1, digits above the highest non-zero digit show SEG_OFF. Digit 0 is never blanked, so value 0 shows '0'.
//  Hex mode: digits >= ceil(DATA_W/4) show '0' (or blank).
//  ovf rules:
//   Hex: ovf=1 if ceil(DATA_W/4) > N_DIGITS.
//   Decimal: ovf=1 if any BCD digit at position >= N_DIGITS is non-zero.
//   While ovf=1, all digits show SEG_DASH regardless of blank_lz.
//  Simultaneous events:
//   reset beats everything.
//   load on the same cycle busy falls is ignored: busy is still 1 that cycle.
//   A digit advance during the display update shows the new value from the next register cycle.
//  Reset mid-conversion: aborts the conversion. busy=0 next cycle. The display returns to 0.
// STRUCTURE
//  Package seg7_pkg:
//   function hex2seg(4b)->7b, active-high.
//   SEG_DASH, SEG_OFF constants.
//   clog2 helper.
//   function ndec(w) = decimal digits of 2^w-1.
//  Polarity inversion is applied only at the output flops.
//  Sub-module seg7_bin2bcd #(DATA_W):
//   sequential double-dabble, add-3 then shift.
//   ports clk, reset, start, bin, busy, done, bcd[4*ndec(DATA_W)-1:0].
//  Top: load capture, display regs, scan counters, PWM compare, blank/ovf mux, output regs.
// TESTING  (DATA_W=8, N_DIGITS=4, SCAN_DIV=32, active-low, bright=15 unless stated)
//  1. Hold reset 5 cycles -> anode=4'hF, seg=7'h7F during reset.
//     After release, anode steps 1110,1101,1011,0111 every 32 clk. seg = 7'h40 ('0') on every digit, blank_lz=0.
//  2. load data=145, mode=1, blank_lz=1 -> busy=1 for 8 cycles.
//     Then digits 0..3 = '5' 7'h12, '4' 7'h19, '1' 7'h79, OFF 7'h7F. ovf=0.
//  3. load 8'hD5, mode=0 -> digits '5' 7'h12, 'd' 7'h21, '0', '0' with busy=0.
//     Then set blank_lz=1 -> digits 2,3 = 7'h7F from the next slot.
//  4. bright=3 -> each anode active 8 of 32 clocks, in phases 0-3 of its slot. bright=15 -> 32 of 32.
//  5. DATA_W=12, N_DIGITS=3: load 4095, mode=1 -> ovf=1, all digits 7'h3F ('-').
//     Then load 999 -> ovf=0, '9','9','9'.
//  6. load 200 (dec), then load 77 at busy cycle 3 -> 77 dropped, display '2','0','0'.
//     Repeat with reset at busy cycle 4 -> busy=0 next cycle, display '0'.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table, segment constants and elaboration-time helpers for the
// multiplexed 7-segment scan driver.
package seg7_pkg;

    // Segment vectors are {g,f,e,d,c,b,a}, active-high inside the design
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Returns at least 1 so that counters always get a legal width
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Number of decimal digits needed for 2^w-1
    function automatic int ndec(input int w);
        logic [63:0] maxv;
        logic [63:0] p;
        int          n;
        maxv = (64'd1 << w) - 64'd1;
        n    = 1;
        p    = 64'd10;
        for (int i = 0; i < 19; i++) begin
            if (p <= maxv) begin
                n = n + 1;
                p = p * 64'd10;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential double-dabble converter: one add-3-then-shift step per clock.
// bcd/done expose the result of the step taken in the final busy cycle.
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [DATA_W-1:0]           bin,
    output logic                        busy,
    output logic                        done,
    output logic [4*ndec(DATA_W)-1:0]   bcd
);

    localparam int ND = ndec(DATA_W);
    localparam int CW = clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] bin_reg;
    logic [4*ND-1:0]   bcd_reg;
    logic [4*ND-1:0]   adj;
    logic [4*ND-1:0]   bcd_next;
    logic [CW-1:0]     cnt_reg;
    logic              busy_reg;

    always_comb begin
        adj = bcd_reg;
        for (int d = 0; d < ND; d++) begin
            if (bcd_reg[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_reg[4*d +: 4] + 4'd3;
            end
        end
        bcd_next = {adj[4*ND-2:0], bin_reg[DATA_W-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            bin_reg  <= '0;
            bcd_reg  <= '0;
        end else if (busy_reg) begin
            bin_reg <= bin_reg << 1;
            bcd_reg <= bcd_next;
            if (cnt_reg == LAST) begin
                busy_reg <= 1'b0;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else if (start) begin
            bin_reg  <= bin;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end
    end

    assign busy = busy_reg;
    assign done = busy_reg && (cnt_reg == LAST);
    assign bcd  = bcd_next;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: captures a binary value in hex or decimal,
// time-scans the digits with 16-phase brightness PWM and flags overflow.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV      = 1600,
    parameter bit ANODE_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   data,
    input  logic                load,
    input  logic                mode,
    input  logic                blank_lz,
    input  logic [3:0]          bright,
    output logic                busy,
    output logic                ovf,
    output logic [N_DIGITS-1:0] anode,
    output logic [6:0]          seg
);

    localparam int HEXD  = (DATA_W + 3) / 4;
    localparam int ND    = ndec(DATA_W);
    localparam int PRE_N = SCAN_DIV / 16;
    localparam int PW    = clog2(PRE_N);
    localparam int IW    = clog2(N_DIGITS);
    localparam bit HEX_OVF = (HEXD > N_DIGITS);

    logic [4*HEXD-1:0] data_pad;
    logic [4*ND-1:0]   bcd;
    logic              cvt_busy;
    logic              cvt_done;
    logic              dec_ovf;
    logic [3:0]        hex_dig [N_DIGITS];
    logic [3:0]        dec_dig [N_DIGITS];
    logic [3:0]        disp_reg [N_DIGITS];
    logic              ovf_reg;

    logic [PW-1:0]     pre_reg;
    logic [3:0]        phase_reg;
    logic [IW-1:0]     idx_reg;

    logic [N_DIGITS-1:0] keep;
    logic [N_DIGITS-1:0] anode_next;
    logic [6:0]          seg_next;
    logic [N_DIGITS-1:0] anode_reg;
    logic [6:0]          seg_reg;

    assign data_pad = (4*HEXD)'(data);

    seg7_bin2bcd #(.DATA_W(DATA_W)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (load && !cvt_busy && mode),
        .bin   (data),
        .busy  (cvt_busy),
        .done  (cvt_done),
        .bcd   (bcd)
    );

    // Per-digit source selection; digits beyond the source width read as zero
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dig
        if (gi < HEXD) begin : g_hex
            assign hex_dig[gi] = data_pad[4*gi +: 4];
        end else begin : g_hex_zero
            assign hex_dig[gi] = 4'd0;
        end
        if (gi < ND) begin : g_dec
            assign dec_dig[gi] = bcd[4*gi +: 4];
        end else begin : g_dec_zero
            assign dec_dig[gi] = 4'd0;
        end
    end

    if (ND > N_DIGITS) begin : g_dec_ovf
        assign dec_ovf = |bcd[4*ND-1 : 4*N_DIGITS];
    end else begin : g_no_dec_ovf
        assign dec_ovf = 1'b0;
    end

    // A load is only seen when idle; cvt_done implies busy so the two never collide
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) disp_reg[i] <= 4'd0;
            ovf_reg <= 1'b0;
        end else if (cvt_done) begin
            disp_reg <= dec_dig;
            ovf_reg  <= dec_ovf;
        end else if (load && !cvt_busy && !mode) begin
            disp_reg <= hex_dig;
            ovf_reg  <= HEX_OVF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg   <= '0;
            phase_reg <= 4'd0;
            idx_reg   <= '0;
        end else if (pre_reg == PW'(PRE_N - 1)) begin
            pre_reg   <= '0;
            phase_reg <= phase_reg + 4'd1;
            if (phase_reg == 4'd15) begin
                idx_reg <= (idx_reg == IW'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

    // keep[i]: some digit at or above i is non-zero; digit 0 is always kept
    always_comb begin
        logic seen;
        seen = 1'b0;
        keep = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (disp_reg[i] != 4'd0) | (i == 0);
            keep[i] = seen;
        end
    end

    always_comb begin
        anode_next = '0;
        if (phase_reg <= bright) anode_next[idx_reg] = 1'b1;
        if (ovf_reg) begin
            seg_next = SEG_DASH;
        end else if (blank_lz && !keep[idx_reg]) begin
            seg_next = SEG_OFF;
        end else begin
            seg_next = hex2seg(disp_reg[idx_reg]);
        end
    end

    // Single output stage applies polarity to anode and seg together
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_reg <= {N_DIGITS{ANODE_ACT_LOW}};
            seg_reg   <= {7{SEG_ACT_LOW}};
        end else begin
            anode_reg <= anode_next ^ {N_DIGITS{ANODE_ACT_LOW}};
            seg_reg   <= seg_next ^ {7{SEG_ACT_LOW}};
        end
    end

    assign busy  = cvt_busy;
    assign ovf   = ovf_reg;
    assign anode = anode_reg;
    assign seg   = seg_reg;

endmodule
